// File: rtl/axi_burst_ram_if.sv
// AXI-style burst bus between a master and the burst RAM.
// Signal names omit the io_ prefix; the instance name supplies it.
interface axi_burst_ram_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [31:0]         awaddr;
    logic [ID_W-1:0]     awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [31:0]         araddr;
    logic [ID_W-1:0]     arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [ID_W-1:0]     rid;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  araddr, arid, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rid, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output araddr, arid, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rid, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_burst_ram.sv
// Single-port-per-direction burst RAM with independent write and read FSMs,
// one outstanding burst each, FIXED/INCR/WRAP addressing and SLVERR checking.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting write beats
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_WAIT | read latency padding (RD_LATENCY-1 cycles)
// R_DATA | rvalid high, streaming read beats
module axi_burst_ram #(
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int DEPTH      = 65536,
    parameter int RD_LATENCY = 1
) (
    input  logic           clock,
    input  logic           reset,
    axi_burst_ram_if.slave io
);
    localparam int          STRB_W    = DATA_W / 8;
    localparam int          OFF_W     = $clog2(STRB_W);
    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [32:0] DEPTH_L   = 33'(DEPTH);
    localparam logic [2:0]  WAIT_INIT = 3'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b10;
    localparam logic [1:0]  B_FIXED   = 2'b00;
    localparam logic [1:0]  B_WRAP    = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // Whole-burst error: illegal encodings, or the highest beat address leaves the array.
    function automatic logic burst_bad(input logic [31:0] a, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [32:0] span;
        logic [32:0] last;
        logic        bad;
        span = ({25'd0, len} + 33'd1) << size;
        bad  = (burst == 2'b11) || (size > 3'(OFF_W)) ||
               ((burst == B_WRAP) &&
                !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        case (burst)
            B_FIXED: last = {1'b0, a};
            B_WRAP:  last = ({1'b0, a} & ~(span - 33'd1)) + span - 33'd1;
            default: last = {1'b0, a} + ({25'd0, len} << size);
        endcase
        if ((last >> OFF_W) >= DEPTH_L) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] nxt;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            B_FIXED: nxt = a;
            B_WRAP:  nxt = (a & ~mask) | ((a + step) & mask);
            default: nxt = a + step;
        endcase
        return nxt;
    endfunction

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [7:0]  w_beat;
    logic        w_err;
    logic        w_last_err;
    logic        w_final;
    logic        w_mismatch;

    assign w_final    = (w_beat == w_len);
    assign w_mismatch = (io.wlast != w_final);

    always_ff @(posedge clock) begin
        if (!reset && io.wready && io.wvalid && !w_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (io.wstrb[b]) mem[w_addr[OFF_W +: IDX_W]][8*b +: 8] <= io.wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state    <= W_IDLE;
            io.awready <= 1'b1;
            io.wready  <= 1'b0;
            io.bvalid  <= 1'b0;
            io.bid     <= '0;
            io.bresp   <= RESP_OKAY;
            w_addr     <= '0;
            w_len      <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_beat     <= '0;
            w_err      <= 1'b0;
            w_last_err <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (io.awvalid) begin
                    w_addr     <= io.awaddr;
                    w_len      <= io.awlen;
                    w_size     <= io.awsize;
                    w_burst    <= io.awburst;
                    w_beat     <= '0;
                    w_err      <= burst_bad(io.awaddr, io.awlen, io.awsize, io.awburst);
                    w_last_err <= 1'b0;
                    io.bid     <= io.awid;
                    io.awready <= 1'b0;
                    io.wready  <= 1'b1;
                    w_state    <= W_DATA;
                end
                W_DATA: if (io.wvalid) begin
                    if (w_final) begin
                        io.wready <= 1'b0;
                        io.bvalid <= 1'b1;
                        io.bresp  <= (w_err || w_last_err || w_mismatch) ? RESP_ERR : RESP_OKAY;
                        w_state   <= W_RESP;
                    end else begin
                        w_addr     <= next_addr(w_addr, w_len, w_size, w_burst);
                        w_beat     <= w_beat + 8'd1;
                        w_last_err <= w_last_err | w_mismatch;
                    end
                end
                W_RESP: if (io.bready) begin
                    io.bvalid  <= 1'b0;
                    io.awready <= 1'b1;
                    w_state    <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    r_state_t          r_state;
    logic [31:0]       r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_beat;
    logic              r_err;
    logic [2:0]        wait_cnt;
    logic [31:0]       r_next;
    logic [31:0]       r_fetch_addr;
    logic [DATA_W-1:0] r_fetch;
    logic              ar_bad;

    assign r_next = next_addr(r_addr, r_len, r_size, r_burst);
    assign ar_bad = burst_bad(io.araddr, io.arlen, io.arsize, io.arburst);

    // Word read at the edge that presents a beat; a same-edge write lands afterwards.
    always_comb begin
        r_fetch_addr = r_addr;
        case (r_state)
            R_IDLE:  r_fetch_addr = io.araddr;
            R_DATA:  r_fetch_addr = r_next;
            default: r_fetch_addr = r_addr;
        endcase
        r_fetch = mem[r_fetch_addr[OFF_W +: IDX_W]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= R_IDLE;
            io.arready <= 1'b1;
            io.rvalid  <= 1'b0;
            io.rlast   <= 1'b0;
            io.rdata   <= '0;
            io.rid     <= '0;
            io.rresp   <= RESP_OKAY;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_beat     <= '0;
            r_err      <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (io.arvalid) begin
                    r_addr     <= io.araddr;
                    r_len      <= io.arlen;
                    r_size     <= io.arsize;
                    r_burst    <= io.arburst;
                    r_beat     <= '0;
                    r_err      <= ar_bad;
                    io.rid     <= io.arid;
                    io.arready <= 1'b0;
                    if (RD_LATENCY == 1) begin
                        io.rvalid <= 1'b1;
                        io.rdata  <= ar_bad ? '0 : r_fetch;
                        io.rresp  <= ar_bad ? RESP_ERR : RESP_OKAY;
                        io.rlast  <= (io.arlen == 8'd0);
                        r_state   <= R_DATA;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        r_state  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        io.rvalid <= 1'b1;
                        io.rdata  <= r_err ? '0 : r_fetch;
                        io.rresp  <= r_err ? RESP_ERR : RESP_OKAY;
                        io.rlast  <= (r_len == 8'd0);
                        r_state   <= R_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                R_DATA: if (io.rready) begin
                    if (io.rlast) begin
                        io.rvalid  <= 1'b0;
                        io.rlast   <= 1'b0;
                        io.arready <= 1'b1;
                        r_state    <= R_IDLE;
                    end else begin
                        r_addr   <= r_next;
                        r_beat   <= r_beat + 8'd1;
                        io.rdata <= r_err ? '0 : r_fetch;
                        io.rlast <= ((r_beat + 8'd1) == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_ram.sv
// Bench for axi_burst_ram: directed scenarios plus randomized bursts checked
// against an address-formula memory model.
module tb_axi_burst_ram;
    localparam int DEPTH = 65536;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    axi_burst_ram_if #(.DATA_W(32), .ID_W(4)) io ();
    axi_burst_ram_if #(.DATA_W(32), .ID_W(4)) io2 ();

    axi_burst_ram #(.DATA_W(32), .ID_W(4), .DEPTH(DEPTH), .RD_LATENCY(1)) dut (
        .clock(clock), .reset(reset), .io(io));
    axi_burst_ram #(.DATA_W(32), .ID_W(4), .DEPTH(DEPTH), .RD_LATENCY(4)) dut_lat4 (
        .clock(clock), .reset(reset), .io(io2));

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [int unsigned];
    logic [31:0] wd  [256];
    logic [3:0]  ws  [256];
    logic [31:0] got [256];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Beat address from the burst rules, computed directly for beat i.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                              input int burst, input int i);
        longint unsigned al, step, wb, base;
        al   = 64'(a);
        step = 64'd1 << size;
        if (burst == 0) return a;
        if (burst == 2) begin
            wb   = 64'(len + 1) * step;
            base = al - (al % wb);
            return 32'(base + ((al - base) + 64'(i) * step) % wb);
        end
        return 32'(al + 64'(i) * step);
    endfunction

    function automatic bit burst_err(input logic [31:0] a, input int len, input int size, input int burst);
        if (burst == 3 || size > 2) return 1'b1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        for (int i = 0; i <= len; i++)
            if ((beat_addr(a, len, size, burst, i) >> 2) >= 32'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rd_model(input int unsigned idx);
        if (mdl.exists(idx)) return mdl[idx];
        return 32'h0;
    endfunction

    task automatic axi_write(input logic [31:0] a, input int len, input int size, input int burst,
                             input logic [3:0] id, input bit early_last, input bit gaps);
        bit err;
        int n;
        int unsigned idx;
        logic [31:0] w;
        err = burst_err(a, len, size, burst);
        io.awaddr = a; io.awlen = 8'(len); io.awsize = 3'(size); io.awburst = 2'(burst);
        io.awid = id; io.awvalid = 1'b1;
        n = 0;
        while (!io.awready && n < 50) begin tick(); n++; end
        check("aw_wait", 64'(n < 50), 1);
        tick();
        io.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin io.wvalid = 1'b0; tick(); end
            io.wdata = wd[i]; io.wstrb = ws[i];
            io.wlast = early_last ? (i == 0) : (i == len);
            io.wvalid = 1'b1;
            n = 0;
            while (!io.wready && n < 50) begin tick(); n++; end
            check("w_wait", 64'(n < 50), 1);
            tick();
        end
        io.wvalid = 1'b0; io.wlast = 1'b0;
        n = 0;
        while (!io.bvalid && n < 50) begin tick(); n++; end
        check("b_wait", 64'(n < 50), 1);
        check("bresp", io.bresp, (err || (early_last && len > 0)) ? 2'b10 : 2'b00);
        check("bid", io.bid, id);
        io.bready = 1'b1;
        tick();
        io.bready = 1'b0;
        check("bvalid_clear", io.bvalid, 0);
        if (!err) begin
            for (int i = 0; i <= len; i++) begin
                idx = beat_addr(a, len, size, burst, i) >> 2;
                w = rd_model(idx);
                for (int b = 0; b < 4; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
                mdl[idx] = w;
            end
        end
    endtask

    task automatic axi_read(input logic [31:0] a, input int len, input int size, input int burst,
                            input logic [3:0] id, input int stall_at, input int stall_n,
                            input bit rnd_ready, input string tag);
        bit err;
        int n, beat, cyc, stall_left;
        logic [31:0] exp_d;
        err = burst_err(a, len, size, burst);
        io.araddr = a; io.arlen = 8'(len); io.arsize = 3'(size); io.arburst = 2'(burst);
        io.arid = id; io.arvalid = 1'b1;
        n = 0;
        while (!io.arready && n < 50) begin tick(); n++; end
        check({tag, "_ar_wait"}, 64'(n < 50), 1);
        tick();
        io.arvalid = 1'b0;
        check({tag, "_first_rvalid"}, io.rvalid, 1);
        beat = 0; cyc = 0; stall_left = stall_n;
        while (beat <= len && cyc < 400) begin
            if (io.rvalid) begin
                exp_d = err ? 32'h0 : rd_model(beat_addr(a, len, size, burst, beat) >> 2);
                check({tag, "_rdata"}, io.rdata, exp_d);
                check({tag, "_rresp"}, io.rresp, err ? 2'b10 : 2'b00);
                check({tag, "_rlast"}, io.rlast, 64'(beat == len));
                check({tag, "_rid"}, io.rid, id);
            end
            if (beat == stall_at && stall_left > 0) begin
                io.rready = 1'b0;
                stall_left--;
            end else begin
                io.rready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (io.rvalid && io.rready) begin
                got[beat] = io.rdata;
                beat++;
            end
            tick();
            cyc++;
        end
        io.rready = 1'b0;
        check({tag, "_beats"}, beat, len + 1);
        check({tag, "_rvalid_end"}, io.rvalid, 0);
        check({tag, "_arready_end"}, io.arready, 1);
    endtask

    initial begin
        int lat, len, size, burst;
        logic [31:0] a;

        {io.awaddr, io.awid, io.awlen, io.awsize, io.awburst, io.awvalid} = '0;
        {io.wdata, io.wstrb, io.wlast, io.wvalid, io.bready} = '0;
        {io.araddr, io.arid, io.arlen, io.arsize, io.arburst, io.arvalid, io.rready} = '0;
        {io2.awaddr, io2.awid, io2.awlen, io2.awsize, io2.awburst, io2.awvalid} = '0;
        {io2.wdata, io2.wstrb, io2.wlast, io2.wvalid, io2.bready} = '0;
        {io2.araddr, io2.arid, io2.arlen, io2.arsize, io2.arburst, io2.arvalid, io2.rready} = '0;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_awready", io.awready, 1);
        check("rst_arready", io.arready, 1);
        check("rst_wready", io.wready, 0);
        check("rst_bvalid", io.bvalid, 0);
        check("rst_rvalid", io.rvalid, 0);
        check("rst_rlast", io.rlast, 0);
        check("rst_rdata", io.rdata, 0);
        check("rst_ids", {io.rid, io.bid}, 0);
        check("rst_resps", {io.rresp, io.bresp}, 0);

        // Basic INCR write then read.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        axi_write(32'h1000, 3, 2, 1, 4'h3, 1'b0, 1'b0);
        axi_read(32'h1000, 3, 2, 1, 4'h6, -1, 0, 1'b0, "incr");
        for (int i = 0; i < 4; i++) check("incr_literal", got[i], 32'hA0 + 32'(i));

        // WRAP: data equals its own address so the beat order is visible.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h2000 + 32'(4 * i); ws[i] = 4'hF; end
        axi_write(32'h2000, 3, 2, 1, 4'h1, 1'b0, 1'b0);
        axi_read(32'h2008, 3, 2, 2, 4'h2, -1, 0, 1'b0, "wrap");
        check("wrap_b0", got[0], 32'h2008);
        check("wrap_b1", got[1], 32'h200C);
        check("wrap_b2", got[2], 32'h2000);
        check("wrap_b3", got[3], 32'h2004);

        // Byte strobes, then a read with rready held low mid-burst.
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        axi_write(32'h3000, 0, 2, 1, 4'h4, 1'b0, 1'b0);
        wd[0] = 32'h11223344; ws[0] = 4'h5;
        axi_write(32'h3000, 0, 2, 1, 4'h4, 1'b0, 1'b0);
        axi_read(32'h3000, 0, 2, 1, 4'h4, -1, 0, 1'b0, "strb");
        check("strb_literal", got[0], 32'hFF22FF44);
        axi_read(32'h1000, 3, 2, 1, 4'h7, 1, 3, 1'b0, "stall");

        // Premature wlast, out-of-range accesses, illegal WRAP length.
        wd[0] = 32'h1; wd[1] = 32'h2; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(32'h6000, 1, 2, 1, 4'h8, 1'b1, 1'b0);
        wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
        axi_write(32'h0, 0, 2, 1, 4'h0, 1'b0, 1'b0);
        wd[0] = 32'hDEADBEEF;
        axi_write(32'(DEPTH * 4), 0, 2, 1, 4'h9, 1'b0, 1'b0);
        axi_read(32'h0, 0, 2, 1, 4'hA, -1, 0, 1'b0, "oob_nowrite");
        check("oob_nowrite_literal", got[0], 32'h5A5A5A5A);
        axi_read(32'(DEPTH * 4), 0, 2, 1, 4'hB, -1, 0, 1'b0, "oob_read");
        check("oob_read_literal", got[0], 0);
        axi_read(32'h1000, 2, 2, 2, 4'hC, -1, 0, 1'b0, "wrap_len2");

        // Read and write hitting the same word on the same edge.
        wd[0] = 32'hCAFE0001; ws[0] = 4'hF;
        axi_write(32'h5000, 0, 2, 1, 4'h2, 1'b0, 1'b0);
        io.awaddr = 32'h5000; io.awlen = 8'd0; io.awsize = 3'd2; io.awburst = 2'd1; io.awid = 4'h2;
        io.awvalid = 1'b1;
        check("raw_awready", io.awready, 1);
        tick();
        io.awvalid = 1'b0;
        io.wdata = 32'hBEEF0002; io.wstrb = 4'hF; io.wlast = 1'b1; io.wvalid = 1'b1;
        io.araddr = 32'h5000; io.arlen = 8'd0; io.arsize = 3'd2; io.arburst = 2'd1; io.arid = 4'h3;
        io.arvalid = 1'b1;
        check("raw_both_ready", {io.wready, io.arready}, 2'b11);
        tick();
        io.wvalid = 1'b0; io.wlast = 1'b0; io.arvalid = 1'b0;
        check("raw_rvalid", io.rvalid, 1);
        check("raw_prewrite", io.rdata, 32'hCAFE0001);
        io.rready = 1'b1; io.bready = 1'b1;
        tick();
        io.rready = 1'b0; io.bready = 1'b0;
        mdl[32'h5000 >> 2] = 32'hBEEF0002;
        axi_read(32'h5000, 0, 2, 1, 4'h3, -1, 0, 1'b0, "raw_after");
        check("raw_after_literal", got[0], 32'hBEEF0002);

        // Read latency of 4 on the second instance.
        io2.araddr = 32'h0; io2.arlen = 8'd0; io2.arsize = 3'd2; io2.arburst = 2'd1; io2.arid = 4'h1;
        io2.arvalid = 1'b1;
        check("lat4_arready", io2.arready, 1);
        tick();
        io2.arvalid = 1'b0;
        lat = 1;
        while (!io2.rvalid && lat < 20) begin tick(); lat++; end
        check("lat4_cycles", lat, 4);
        io2.rready = 1'b1;
        tick();
        io2.rready = 1'b0;
        check("lat4_done", io2.rvalid, 0);

        // Reset in the middle of a read burst.
        io.araddr = 32'h1000; io.arlen = 8'd3; io.arsize = 3'd2; io.arburst = 2'd1; io.arid = 4'h5;
        io.arvalid = 1'b1;
        check("mid_arready", io.arready, 1);
        tick();
        io.arvalid = 1'b0;
        io.rready = 1'b1;
        tick();
        io.rready = 1'b0;
        check("mid_in_burst", io.rvalid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_rvalid", io.rvalid, 0);
        check("mid_rst_arready", io.arready, 1);
        check("mid_rst_rlast", io.rlast, 0);
        check("mid_rst_rdata_rid", {io.rdata, io.rid}, 0);
        axi_read(32'h1000, 3, 2, 1, 4'h5, -1, 0, 1'b0, "post_rst");
        axi_read(32'h3000, 0, 2, 1, 4'h5, -1, 0, 1'b0, "post_rst_strb");

        // Randomized bursts over a pre-filled region.
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(32'h4000, 255, 2, 1, 4'h0, 1'b0, 1'b0);
        for (int t = 0; t < 24; t++) begin
            burst = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            size  = $urandom_range(0, 2);
            if (burst == 2) begin
                case ($urandom_range(0, 2))
                    0:       len = 1;
                    1:       len = 3;
                    default: len = 7;
                endcase
            end else begin
                len = $urandom_range(0, 7);
            end
            a = 32'h4000 + 32'($urandom_range(0, 32'h2FF));
            a = a & ~(32'((1 << size) - 1));
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            axi_write(a, len, size, burst, 4'($urandom), 1'b0, 1'b1);
            axi_read(a, len, size, burst, 4'($urandom), -1, 0, 1'b1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_burst_ram.md
AXI_BURST_RAM -- requirements
Module: axi_burst_ram
Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-003 SHALL have parameter DEPTH, default 65536, memory size in DATA_W words; power of two.
REQ-004 SHALL have parameter RD_LATENCY, default 1, cycles from AR handshake to first rvalid; legal range 1..8.
REQ-005 SHALL have clock  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have io_awaddr  input  32  write burst start byte address.
REQ-008 SHALL have io_awid  input  ID_W  write transaction ID.
REQ-009 SHALL have io_awlen  input  8  beats minus one.
REQ-010 SHALL have io_awsize  input  3  log2 bytes per beat.
REQ-011 SHALL have io_awburst  input  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-012 SHALL have io_awvalid  input  1  AW valid.
REQ-013 SHALL have io_awready  output  1  AW ready.
REQ-014 SHALL have io_wdata  input  DATA_W  write data.
REQ-015 SHALL have io_wstrb  input  DATA_W/8  byte enables.
REQ-016 SHALL have io_wlast  input  1  final write beat marker.
REQ-017 SHALL have io_wvalid  input  1  W valid.
REQ-018 SHALL have io_wready  output  1  W ready.
REQ-019 SHALL have io_bid  output  ID_W  echoed awid.
REQ-020 SHALL have io_bresp  output  2  00 OKAY, 10 SLVERR.
REQ-021 SHALL have io_bvalid  output  1  B valid.
REQ-022 SHALL have io_bready  input  1  B ready.
REQ-023 SHALL have io_araddr  input  32  read burst start byte address.
REQ-024 SHALL have io_arid, io_arlen, io_arsize, io_arburst  input  ID_W/8/3/2  read ID, length, size, burst, encoded as AW.
REQ-025 SHALL have io_arvalid  input  1 and io_arready  output  1  AR handshake.
REQ-026 SHALL have io_rdata  output  DATA_W  read data.
REQ-027 SHALL have io_rid  output  ID_W  echoed arid.
REQ-028 SHALL have io_rresp  output  2  per-beat response, encoded as bresp.
REQ-029 SHALL have io_rlast  output  1  final read beat marker.
REQ-030 SHALL have io_rvalid  output  1 and io_rready  input  1  R handshake.
Function
REQ-031 SHALL run independent write FSM (W_IDLE->W_DATA->W_RESP->W_IDLE) and read FSM (R_IDLE->R_WAIT->R_DATA->R_IDLE), one outstanding burst each.
REQ-032 SHALL assert awready only in W_IDLE and arready only in R_IDLE; handshake latches addr/id/len/size/burst and zeroes beat counter.
REQ-033 SHALL assert wready throughout W_DATA, writing bytes with wstrb=1 on each W handshake; after beat awlen+1, go to W_RESP with bvalid=1, holding until bready, then W_IDLE.
REQ-034 SHALL use the beat counter, not wlast, to end write bursts; wlast mismatch on any beat sets bresp=SLVERR.
REQ-035 SHALL hold R_WAIT RD_LATENCY-1 cycles (0 means direct to R_DATA), so first rvalid rises RD_LATENCY cycles after the AR handshake.
REQ-036 SHALL in R_DATA present next beat the cycle after each non-last handshake (full throughput); rdata/rresp/rlast/rid stay stable while rvalid && !rready; rlast=1 on beat arlen+1; its handshake returns to R_IDLE.
REQ-037 SHALL advance address per beat: FIXED unchanged; INCR +2^size; WRAP +2^size wrapped in aligned (len+1)*2^size window; burst 11 handled as INCR.
REQ-038 SHALL flag SLVERR for the whole burst when burst=11, size>log2(DATA_W/8), WRAP with len not 1/3/7/15, or any beat word index >= DEPTH; such beats suppress writes and return rdata=0; index = addr[31:log2(DATA_W/8)], no modulo.
REQ-039 SHALL on same-cycle read beat and write to same word return pre-write data.
Reset
REQ-040 SHALL on reset (also mid-burst) force both FSMs idle, deassert bvalid, rvalid, rlast, wready, zero bid/rid/bresp/rresp/rdata, set awready=arready=1 next cycle, leave memory contents unchanged.
Verification
REQ-041 SHALL pass: INCR write 0x1000 len=3 size=2, data 0xA0..0xA3 strb 0xF, then INCR read -> rdata 0xA0,0xA1,0xA2,0xA3, rlast on beat 4, bresp=rresp=00.
REQ-042 SHALL pass: WRAP read 0x2008 len=3 size=2 -> addresses 0x2008,0x200C,0x2000,0x2004.
REQ-043 SHALL pass: write 0x3000 data 0x11223344 strb 0x5 over 0xFFFFFFFF -> read 0xFF22FF44; rready low 3 cycles mid-burst -> rdata held, no beat lost.
REQ-044 SHALL pass: awlen=1 with wlast on beat 1 -> bresp=10; read at word DEPTH -> rresp=10, rdata=0; RD_LATENCY=4 -> first rvalid 4 cycles after AR; reset mid-read burst -> rvalid 0 next cycle, arready 1, prior memory contents intact.
